// File: rtl/tx_sched_pkg.sv
// Shared types and default constants for the TX channel scheduler.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } sched_state_e;

    localparam int TX_SCHED_NUM_REQ = 3;
    localparam int TX_SCHED_IDX_W   = 2;
    localparam int TX_SCHED_TMO_W   = 12;
    localparam int TX_SCHED_STATS_W = 16;

endpackage

// File: rtl/tx_chan_scheduler_if.sv
// Request/grant bundle between the packet RAMs and the scheduler.
interface tx_chan_scheduler_if
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ = TX_SCHED_NUM_REQ,
    parameter int IDX_W   = TX_SCHED_IDX_W
);
    // pkt_waiting is a level request; grant is held until the granted RAM pulses
    // its req_done bit (or the watchdog pulses timeout_abort), then drops for at
    // least two cycles before any new grant. Other req_done bits are ignored.
    logic [NUM_REQ-1:0] pkt_waiting;
    logic [NUM_REQ-1:0] req_done;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] timeout_abort;

    modport master (
        input  pkt_waiting, req_done,
        output grant, grant_valid, grant_idx, timeout_abort
    );

    modport slave (
        output pkt_waiting, req_done,
        input  grant, grant_valid, grant_idx, timeout_abort
    );

endinterface

// File: rtl/tx_chan_scheduler_rr_pick.sv
// Combinational round-robin selector with optional override for the top requester.
module rr_pick
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ = TX_SCHED_NUM_REQ,
    parameter int IDX_W   = TX_SCHED_IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               prio,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        if (prio && req[NUM_REQ-1]) begin
            gnt[NUM_REQ-1] = 1'b1;
            idx            = IDX_W'(NUM_REQ - 1);
        end else begin
            // ptr is always < NUM_REQ, so a single subtraction wraps the search
            for (int i = 0; i < NUM_REQ; i++) begin
                j = int'(ptr) + i;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (!found && req[IDX_W'(j)]) begin
                    found             = 1'b1;
                    gnt[IDX_W'(j)]    = 1'b1;
                    idx               = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/tx_chan_scheduler.sv
// Round-robin owner of the shared TX packet-read path with watchdog abort.
// Optional per-requester grant counters are built when TX_SCHED_STATS_EN is defined.
module tx_chan_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ = TX_SCHED_NUM_REQ,
    parameter int IDX_W   = TX_SCHED_IDX_W,
    parameter int TMO_W   = TX_SCHED_TMO_W
) (
    input  logic                        txclk,
    input  logic                        reset,
    input  logic                        sched_en,
    input  logic                        cmd_priority,
    input  logic [TMO_W-1:0]            timeout_cycles,
    input  logic [IDX_W-1:0]            stats_sel,
    output logic [TX_SCHED_STATS_W-1:0] stats_count,
    output logic [1:0]                  fsm_state,
    tx_chan_scheduler_if.master         bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_GRANT   = GRANT;
    localparam logic [1:0] S_RELEASE = RELEASE;

    logic [1:0]         state;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] abort_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [TMO_W-1:0]   wd_cnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant_start;
    logic               done;
    logic               tmo_hit;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req  (bus.pkt_waiting),
        .ptr  (rr_ptr),
        .prio (cmd_priority),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign grant_start = (state == S_IDLE) && sched_en && (|bus.pkt_waiting);
    assign done        = bus.req_done[idx_q];
    assign tmo_hit     = (timeout_cycles != '0) && (wd_cnt == timeout_cycles - TMO_W'(1));

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            grant_q <= '0;
            abort_q <= '0;
            idx_q   <= '0;
            rr_ptr  <= '0;
            wd_cnt  <= '0;
        end else begin
            abort_q <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_start) begin
                        grant_q <= pick_gnt;
                        idx_q   <= pick_idx;
                        wd_cnt  <= '0;
                        state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
                    // done takes precedence over a coincident timeout
                    if (done) begin
                        grant_q <= '0;
                        state   <= S_RELEASE;
                    end else if (tmo_hit) begin
                        grant_q <= '0;
                        abort_q <= grant_q;
                        state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    rr_ptr <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = |grant_q;
    assign bus.grant_idx     = idx_q;
    assign bus.timeout_abort = abort_q;
    assign fsm_state         = state;

`ifdef TX_SCHED_STATS_EN
    logic [TX_SCHED_STATS_W-1:0] cnt [NUM_REQ];

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else if (grant_start) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_gnt[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stats_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stats_sel == IDX_W'(i)) stats_count = cnt[i];
        end
    end
`else
    logic stats_unused;
    assign stats_unused = ^stats_sel;
    assign stats_count  = '0;
`endif

endmodule
